uart_tx_drain_ctrl: RTL and testbench
=====================================

// Module: uart_tx_drain_ctrl
// PURPOSE
//   Drain controller between the echo RX FIFO and the UART transmitter.
//   - Pops one byte whenever the FIFO is non-empty, hands it to the UART TX, and waits for completion before the next pop.
//   - Replaces the read-only-when-full scheme; adds optional CR->CRLF expansion, a completion timeout and a sent-byte counter.
// PARAMETERS
//   DATA_BITS       8        byte width
//   READ_LATENCY    1        FIFO cycles from read_out edge to valid data (0..3)
//   GAP_CYCLES      2        idle cycles inserted after each byte (0..255)
//   TIMEOUT_CYCLES  20000    max cycles waiting for tx_done_in (>=2)
//   CRLF_EXPAND     1        1: after sending 0x0D, auto-send 0x0A
//   CNT_WIDTH       16       width of tx_count_out
// PORTS
//   sysclk          in   1          clock
//   rst_in          in   1          asynchronous, active-high reset
//   enable_in       in   1          allow new pops from FIFO
//   fifo_empty_in   in   1          FIFO empty flag
//   fifo_data_in    in   DATA_BITS  FIFO read data
//   fifo_read_out   out  1          FIFO pop strobe, 1 cycle
//   tx_done_in      in   1          UART TX done; rising edge = byte complete
//   tx_data_out     out  DATA_BITS  byte to UART, stable from SEND to end of WAIT
//   data_rdy_out    out  1          UART start strobe, 1 cycle
//   busy_out        out  1          state != IDLE
//   err_timeout_out out  1          sticky: a tx_done_in wait timed out
//   tx_count_out    out  CNT_WIDTH  bytes completed, incl. inserted LFs; wraps
// BEHAVIOUR
//   Clock and reset: one clock, sysclk; rst_in is asynchronous, active-high.
//   Reset state: IDLE; all outputs 0; byte reg, counters and tx_done edge detector cleared.
//   States: IDLE, POP, LATCH, SEND, WAIT, GAP. fifo_read_out=(POP); data_rdy_out=(SEND).
//   IDLE : enable_in & ~fifo_empty_in -> POP; else stay.
//   POP  : exactly 1 cycle. Next state LATCH if READ_LATENCY>0.
//          READ_LATENCY=0: capture fifo_data_in at this edge -> SEND.
//   LATCH: READ_LATENCY cycles; capture fifo_data_in on last edge -> SEND.
//   SEND : 1 cycle; tx_data_out holds byte; clear timeout counter -> WAIT.
//   WAIT : edge detect on registered tx_done_in; rise -> tx_count_out+1, then:
//          - CRLF_EXPAND & byte==0x0D & ~lf_pending -> load 0x0A, set lf_pending, -> SEND;
//          - else clear lf_pending -> GAP.
//          Counter reaches TIMEOUT_CYCLES without rise -> set err_timeout_out,
//          no count increment, drop byte and any pending LF -> GAP.
//   GAP  : GAP_CYCLES cycles (0 => pass through 1 cycle) -> IDLE.
//   Latency: from the IDLE edge that sees non-empty, data_rdy_out is high in cycle READ_LATENCY+2 (cycle 1 = POP).
//   Exactly one pop per byte; never pops when fifo_empty_in=1 or outside POP.
//   A tx_done_in already high on entering WAIT is not a completion; a fresh rising edge is required.
//   enable_in low mid-byte: current byte and its pending LF complete; stop at IDLE.
//   FIFO becomes empty during GAP: stay in IDLE, no spurious pop.
//   Inserted 0x0A consumes no FIFO entry; a 0x0D popped from FIFO after an LF is expanded again.
//   tx_count_out wraps 2^CNT_WIDTH-1 -> 0. err_timeout_out clears only on rst_in.
//   rst_in mid-operation: immediate return to reset state; in-flight byte lost; no strobe glitch.
// TESTING
//   1. FIFO holds 0x41,0x42, UART model completes 100 cycles after each start ->
//      two pops, bytes sent in order, tx_count_out=2, data_rdy_out one cycle each.
//   2. READ_LATENCY=1: empty->non-empty at edge E0 -> read_out high cycle 1,
//      data_rdy_out high cycle 3; repeat with READ_LATENCY=0 -> cycle 2.
//   3. FIFO 0x0D,0x58 with CRLF_EXPAND=1 -> UART sees 0x0D,0x0A,0x58; 2 pops, count=3.
//   4. UART never asserts done, TIMEOUT_CYCLES=50 -> err_timeout_out=1 at cycle 50 of WAIT,
//      back to IDLE, next byte still sent.
//   5. enable_in drops during WAIT of 0x0D -> 0x0D,0x0A complete, no further pop while FIFO non-empty.
//   6. rst_in pulsed mid-WAIT with CNT_WIDTH=4 and count=15 -> all outputs 0 immediately;
//      separately, one byte from count=15 -> wrap to 0.

Source files
------------

// File: rtl/uart_tx_drain_ctrl.sv
// uart_tx_drain_ctrl
//   Drains the echo RX FIFO into the UART transmitter one byte at a time.
//   Each popped byte is handed to the UART with a one-cycle start strobe.
//   The controller then waits for a fresh rising edge of tx_done_in before it
//   inserts an idle gap and returns to IDLE.
//   Optional CR->CRLF expansion sends an extra 0x0A without consuming a FIFO
//   entry. A stuck UART is abandoned after TIMEOUT_CYCLES and flagged in a
//   sticky error bit.
module uart_tx_drain_ctrl #(
  parameter int DATA_BITS      = 8,
  parameter int READ_LATENCY   = 1,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int CRLF_EXPAND    = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 sysclk,
  input  logic                 rst_in,
  input  logic                 enable_in,
  input  logic                 fifo_empty_in,
  input  logic [DATA_BITS-1:0] fifo_data_in,
  output logic                 fifo_read_out,
  input  logic                 tx_done_in,
  output logic [DATA_BITS-1:0] tx_data_out,
  output logic                 data_rdy_out,
  output logic                 busy_out,
  output logic                 err_timeout_out,
  output logic [CNT_WIDTH-1:0] tx_count_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LATCH,
    S_SEND,
    S_WAIT,
    S_GAP
  } state_e;

  // One shared cycle counter serves LATCH, WAIT and GAP. It must be wide
  // enough for both the timeout and the largest gap.
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW   = (TO_W > 8) ? TO_W : 8;

  localparam logic [CW-1:0] LAT_LAST = CW'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [DATA_BITS-1:0] CR_BYTE = DATA_BITS'(8'h0D);
  localparam logic [DATA_BITS-1:0] LF_BYTE = DATA_BITS'(8'h0A);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   byte_q, byte_d;
  logic                   lf_pending_q, lf_pending_d;
  logic                   err_q, err_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   done_q, done_prev_q;
  logic                   rd_q, rdy_q, busy_q;
  logic                   done_rise;

  // A completion is a 0->1 transition of the registered done input. A level
  // that was already high before WAIT never produces it.
  assign done_rise = done_q & ~done_prev_q;

  // Next-state, datapath and counter updates.
  always_comb begin
    // NOTE: every signal gets a default before the case; a path that leaves
    // one unassigned would infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    byte_d       = byte_q;
    lf_pending_d = lf_pending_q;
    err_d        = err_q;
    count_d      = count_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (enable_in && !fifo_empty_in) begin
          state_d = S_POP;
        end
      end

      S_POP: begin
        cnt_d = '0;
        if (READ_LATENCY == 0) begin
          byte_d  = fifo_data_in;
          state_d = S_SEND;
        end else begin
          state_d = S_LATCH;
        end
      end

      S_LATCH: begin
        if (cnt_q == LAT_LAST) begin
          byte_d  = fifo_data_in;
          cnt_d   = '0;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (done_rise) begin
          count_d = count_q + CNT_WIDTH'(1);
          cnt_d   = '0;
          if ((CRLF_EXPAND != 0) && (byte_q == CR_BYTE) && !lf_pending_q) begin
            byte_d       = LF_BYTE;
            lf_pending_d = 1'b1;
            state_d      = S_SEND;
          end else begin
            lf_pending_d = 1'b0;
            state_d      = S_GAP;
          end
        end else if (cnt_q == TO_LAST) begin
          // Give up on this byte: not counted, and any pending LF is dropped.
          err_d        = 1'b1;
          lf_pending_d = 1'b0;
          cnt_d        = '0;
          state_d      = S_GAP;
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, datapath and registered strobes. Strobes come straight from flops
  // so they cannot glitch.
  always_ff @(posedge sysclk or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      byte_q       <= '0;
      lf_pending_q <= 1'b0;
      err_q        <= 1'b0;
      count_q      <= '0;
      done_q       <= 1'b0;
      done_prev_q  <= 1'b0;
      rd_q         <= 1'b0;
      rdy_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // flop samples pre-edge values regardless of statement order.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      byte_q       <= byte_d;
      lf_pending_q <= lf_pending_d;
      err_q        <= err_d;
      count_q      <= count_d;
      done_q       <= tx_done_in;
      done_prev_q  <= done_q;
      rd_q         <= (state_d == S_POP);
      rdy_q        <= (state_d == S_SEND);
      busy_q       <= (state_d != S_IDLE);
    end
  end

  assign fifo_read_out   = rd_q;
  assign data_rdy_out    = rdy_q;
  assign busy_out        = busy_q;
  assign tx_data_out     = byte_q;
  assign err_timeout_out = err_q;
  assign tx_count_out    = count_q;

endmodule

// File: tb/tb_uart_tx_drain_ctrl.sv
// Bench for uart_tx_drain_ctrl. Two instances run side by side:
//   inst 0: READ_LATENCY=1, GAP=2, TIMEOUT=200, 4-bit counter
//   inst 1: READ_LATENCY=0, GAP=0, TIMEOUT=50, 16-bit counter
// The FIFO and UART are behavioural models. The expected UART byte stream and
// byte count come from a reference model that works on whole bytes. Each
// byte is sent, a CR adds an LF, a timed-out byte is not counted, and a reset
// clears the count.
module tb_uart_tx_drain_ctrl;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // DUT-facing signals, one element per instance
  logic       rst   [2];
  logic       en    [2];
  logic       empty [2];
  logic [7:0] fdata [2];
  logic       rd    [2];
  logic       done  [2];
  logic [7:0] txd   [2];
  logic       rdy   [2];
  logic       busy  [2];
  logic       err   [2];
  logic [3:0]  cnt_a;
  logic [15:0] cnt_b;

  // FIFO model
  logic [7:0] fmem [2][256];
  int         wp [2];
  int         rp [2];
  logic [7:0] fdata0_q;

  // UART model and protocol monitor
  logic [7:0] obs [2][256];
  int         on [2];
  int         rem [2];
  int         bad [2];
  logic [7:0] cur_b [2];
  logic       rd_prev [2];
  logic       rdy_prev [2];
  int         dly_lo [2];
  int         dly_hi [2];
  logic       never [2];

  // Reference model
  logic [7:0] exp_b [2][256];
  int         exp_n [2];
  int         exp_cnt [2];
  int         cmp_base [2];
  logic       exp_err [2];

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_drain_ctrl #(
    .DATA_BITS(8), .READ_LATENCY(1), .GAP_CYCLES(2),
    .TIMEOUT_CYCLES(200), .CRLF_EXPAND(1), .CNT_WIDTH(4)
  ) dut_a (
    .sysclk(sysclk), .rst_in(rst[0]), .enable_in(en[0]),
    .fifo_empty_in(empty[0]), .fifo_data_in(fdata[0]), .fifo_read_out(rd[0]),
    .tx_done_in(done[0]), .tx_data_out(txd[0]), .data_rdy_out(rdy[0]),
    .busy_out(busy[0]), .err_timeout_out(err[0]), .tx_count_out(cnt_a)
  );

  uart_tx_drain_ctrl #(
    .DATA_BITS(8), .READ_LATENCY(0), .GAP_CYCLES(0),
    .TIMEOUT_CYCLES(50), .CRLF_EXPAND(1), .CNT_WIDTH(16)
  ) dut_b (
    .sysclk(sysclk), .rst_in(rst[1]), .enable_in(en[1]),
    .fifo_empty_in(empty[1]), .fifo_data_in(fdata[1]), .fifo_read_out(rd[1]),
    .tx_done_in(done[1]), .tx_data_out(txd[1]), .data_rdy_out(rdy[1]),
    .busy_out(busy[1]), .err_timeout_out(err[1]), .tx_count_out(cnt_b)
  );

  // FIFO flags and read data: inst 0 has a registered read port, and inst 1
  // is first-word fall-through.
  always_comb begin
    empty[0] = (wp[0] == rp[0]);
    empty[1] = (wp[1] == rp[1]);
    fdata[0] = fdata0_q;
    fdata[1] = fmem[1][rp[1] % 256];
  end

  // FIFO pops, UART behaviour (done idles high, drops on start, rises after
  // a delay) and protocol violation counting.
  always @(posedge sysclk) begin : env
    int nb;
    if (rd[0]) fdata0_q <= fmem[0][rp[0] % 256];
    for (int i = 0; i < 2; i++) begin
      nb = 0;
      rd_prev[i]  <= rd[i];
      rdy_prev[i] <= rdy[i];
      if (rd[i]) begin
        rp[i] <= rp[i] + 1;
        if (rd_prev[i] || empty[i]) nb++;
      end
      if (rdy[i] && rdy_prev[i]) nb++;
      if (rst[i]) begin
        rem[i]  <= 0;
        done[i] <= 1'b1;
      end else if (rdy[i]) begin
        obs[i][on[i] % 256] <= txd[i];
        on[i]    <= on[i] + 1;
        cur_b[i] <= txd[i];
        if (rem[i] > 0) nb++;
        done[i] <= 1'b0;
        rem[i]  <= never[i] ? 0 : int'($urandom_range(dly_hi[i], dly_lo[i]));
      end else if (rem[i] > 0) begin
        if (rem[i] == 1) begin
          done[i] <= 1'b1;
          if (txd[i] != cur_b[i]) nb++;
        end
        rem[i] <= rem[i] - 1;
      end
      if (!rst[i] && !busy[i] && rem[i] > 0) nb++;
      bad[i] <= bad[i] + nb;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] b);
    fmem[i][wp[i] % 256] = b;
    wp[i]++;
  endtask

  // Reference: what the UART should see and how the counter should move.
  task automatic expect_byte(input int i, input logic [7:0] b, input bit ok);
    exp_b[i][exp_n[i] % 256] = b;
    exp_n[i]++;
    if (ok) begin
      exp_cnt[i]++;
      if (b == 8'h0D) begin
        exp_b[i][exp_n[i] % 256] = 8'h0A;
        exp_n[i]++;
        exp_cnt[i]++;
      end
    end
  endtask

  task automatic feed(input int i, input logic [7:0] b);
    push(i, b);
    expect_byte(i, b, 1'b1);
  endtask

  task automatic wait_quiet(input int i, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge sysclk);
      if (!busy[i] && (empty[i] || !en[i])) break;
    end
    check($sformatf("quiet_budget%0d", i), 32'(k < budget), 32'd1);
  endtask

  task automatic wait_rdy(input int i, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge sysclk);
      if (rdy[i]) break;
    end
    check($sformatf("rdy_budget%0d", i), 32'(k < budget), 32'd1);
  endtask

  task automatic check_all(input int i, input int pending);
    logic [15:0] c;
    int          m;
    check($sformatf("n_sent%0d", i), on[i], exp_n[i]);
    for (int k = cmp_base[i]; k < exp_n[i]; k++)
      check($sformatf("byte%0d[%0d]", i, k), obs[i][k % 256], exp_b[i][k % 256]);
    cmp_base[i] = exp_n[i];
    check($sformatf("fifo_left%0d", i), wp[i] - rp[i], pending);
    c = (i == 0) ? {12'd0, cnt_a} : cnt_b;
    m = (i == 0) ? 16 : 65536;
    check($sformatf("count%0d", i), c, exp_cnt[i] % m);
    check($sformatf("err%0d", i), err[i], exp_err[i]);
    check($sformatf("protocol%0d", i), bad[i], 0);
  endtask

  task automatic latency(input int i, input int exp_rdy);
    int k_rd;
    int k_rdy;
    k_rd  = 0;
    k_rdy = 0;
    feed(i, 8'h55);
    for (int k = 1; k <= 10; k++) begin
      @(negedge sysclk);
      if (rd[i] && k_rd == 0) k_rd = k;
      if (rdy[i] && k_rdy == 0) k_rdy = k;
    end
    check($sformatf("lat_pop%0d", i), k_rd, 1);
    check($sformatf("lat_rdy%0d", i), k_rdy, exp_rdy);
  endtask

  task automatic random_burst(input int i, input int n);
    logic [7:0] b;
    dly_lo[i] = 2;
    dly_hi[i] = 40;
    for (int k = 0; k < n; k++) begin
      b = 8'($urandom);
      if ($urandom_range(3, 0) == 0) b = 8'h0D;
      feed(i, b);
      if ($urandom_range(1, 0) == 1) @(negedge sysclk);
    end
    wait_quiet(i, 5000);
    check_all(i, 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int t;
    int n;
    int snap;
    logic [7:0] b;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; en[i] = 1'b0; never[i] = 1'b0;
      dly_lo[i] = 5; dly_hi[i] = 20;
      wp[i] = 0; exp_n[i] = 0; exp_cnt[i] = 0; cmp_base[i] = 0; exp_err[i] = 1'b0;
    end
    repeat (3) @(negedge sysclk);

    // Reset state
    check("rst_out0", {rd[0], rdy[0], busy[0], err[0], txd[0], cnt_a}, 0);
    check("rst_out1", {rd[1], rdy[1], busy[1], err[1], txd[1], cnt_b}, 0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge sysclk);

    // Two bytes, UART takes 100 cycles each
    dly_lo[0] = 100; dly_hi[0] = 100;
    feed(0, 8'h41);
    feed(0, 8'h42);
    en[0] = 1'b1;
    wait_quiet(0, 2000);
    check_all(0, 0);

    // Start latency, READ_LATENCY=1 then 0
    dly_lo[0] = 5; dly_hi[0] = 20;
    latency(0, 3);
    wait_quiet(0, 2000);
    check_all(0, 0);
    en[1] = 1'b1;
    latency(1, 2);
    wait_quiet(1, 2000);
    check_all(1, 0);

    // CR expansion
    feed(0, 8'h0D);
    feed(0, 8'h58);
    wait_quiet(0, 2000);
    check_all(0, 0);

    // Randomized bursts against the reference stream
    random_burst(0, 10);
    random_burst(1, 12);

    // Timeout on a CR: not counted, no LF, sticky error, next byte still sent
    never[1] = 1'b1;
    push(1, 8'h0D);
    expect_byte(1, 8'h0D, 1'b0);
    wait_rdy(1, 200);
    t = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge sysclk);
      if (err[1]) begin
        t = k;
        break;
      end
    end
    check("timeout_cycle", t, 51);
    wait_quiet(1, 500);
    exp_err[1] = 1'b1;
    check_all(1, 0);
    never[1] = 1'b0;
    feed(1, 8'h44);
    wait_quiet(1, 500);
    check_all(1, 0);

    // Enable drops during WAIT of a CR: CR and LF finish, no further pop
    dly_lo[0] = 60; dly_hi[0] = 60;
    feed(0, 8'h0D);
    push(0, 8'h41);
    push(0, 8'h42);
    wait_rdy(0, 200);
    repeat (5) @(negedge sysclk);
    en[0] = 1'b0;
    wait_quiet(0, 2000);
    check_all(0, 2);
    snap = rp[0];
    repeat (30) @(negedge sysclk);
    check("no_pop_disabled", rp[0], snap);
    check("idle_disabled", busy[0], 1'b0);
    expect_byte(0, 8'h41, 1'b1);
    expect_byte(0, 8'h42, 1'b1);
    en[0] = 1'b1;
    wait_quiet(0, 2000);
    check_all(0, 0);

    // Bring the 4-bit counter to 15
    dly_lo[0] = 3; dly_hi[0] = 8;
    n = (15 - (exp_cnt[0] % 16) + 16) % 16;
    for (int k = 0; k < n; k++) begin
      b = 8'($urandom);
      if (b == 8'h0D) b = 8'h0E;
      feed(0, b);
    end
    wait_quiet(0, 3000);
    check_all(0, 0);
    check("pre_rst_count", cnt_a, 4'd15);

    // Reset in the middle of WAIT: everything returns to zero at once
    dly_lo[0] = 100; dly_hi[0] = 100;
    push(0, 8'h61);
    wait_rdy(0, 200);
    repeat (5) @(negedge sysclk);
    check("busy_before_rst", busy[0], 1'b1);
    #2 rst[0] = 1'b1;
    #1 check("rst_mid_out", {rd[0], rdy[0], busy[0], err[0], txd[0], cnt_a}, 0);
    @(negedge sysclk);
    rst[0] = 1'b0;
    expect_byte(0, 8'h61, 1'b0);
    exp_cnt[0] = 0;
    repeat (3) @(negedge sysclk);
    check_all(0, 0);

    // Count 15 -> wrap to 0
    dly_lo[0] = 3; dly_hi[0] = 8;
    for (int k = 0; k < 15; k++) feed(0, 8'h30 + 8'(k));
    wait_quiet(0, 3000);
    check_all(0, 0);
    feed(0, 8'h7A);
    wait_quiet(0, 500);
    check_all(0, 0);
    check("wrap_zero", cnt_a, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
